vd_ctrl: RTL and testbench

VD_CTRL -- requirements
Module: vd_ctrl

---
 rtl/vd_pkg.sv | 14 +
 rtl/vd_addr_gen.sv | 57 +++++
 rtl/vd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_vd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vd_pkg.sv
// Shared types and defaults for the Viterbi decoder control slice.
package vd_pkg;

    localparam int unsigned TbDepthDefault = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StTbWait,
        StFlush,
        StDone
    } vd_state_e;

endpackage

// File: rtl/vd_addr_gen.sv
// Survivor-memory write address and traceback block counter.
module vd_addr_gen
    import vd_pkg::*;
#(
    parameter int unsigned TB_DEPTH = TbDepthDefault,
    parameter int unsigned AW       = $clog2(2 * TB_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [AW-1:0] addr_o,
    output logic          boundary_o
);

    localparam int unsigned CW = $clog2(TB_DEPTH);
    localparam logic [AW-1:0] AddrMax = AW'(2 * TB_DEPTH - 1);
    localparam logic [CW-1:0] CntMax  = CW'(TB_DEPTH - 1);

    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clr_i) begin
            addr_d = '0;
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (adv_i) begin
            addr_d = (addr_q == AddrMax) ? '0 : addr_q + 1'b1;
            cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
            // Saturates once the first full block has gone by.
            if (cnt_q == CntMax) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign addr_o     = addr_q;
    assign boundary_o = (cnt_q == CntMax) && full_q;

endmodule

// File: rtl/vd_ctrl.sv
// Viterbi decoder controller: symbol intake, ACS strobes, normalisation and
// traceback launch sequencing.
module vd_ctrl
    import vd_pkg::*;
#(
    parameter int unsigned TB_DEPTH = TbDepthDefault,
    parameter int unsigned AW       = $clog2(2 * TB_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [1:0]    in_pair,
    input  logic          in_last,
    output logic          in_ready,
    output logic [1:0]    bmc_pair,
    output logic          acs_en,
    input  logic          norm_req,
    output logic          sm_norm,
    output logic [AW-1:0] sv_wr_addr,
    output logic          tb_start,
    output logic [AW-1:0] tb_addr,
    output logic          tb_final,
    input  logic          tb_busy,
    output logic          frame_done
);

    vd_state_e     state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [1:0]    bmc_pair_q, bmc_pair_d;
    logic          acs_en_q, acs_en_d;
    logic          sm_norm_q, sm_norm_d;
    logic          norm_pend_q, norm_pend_d;
    logic [AW-1:0] sv_wr_addr_q, sv_wr_addr_d;
    logic          tb_start_q, tb_start_d;
    logic [AW-1:0] tb_addr_q, tb_addr_d;
    logic          tb_final_q, tb_final_d;
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          done_fire;
    logic [AW-1:0] gen_addr;
    logic          gen_boundary;

    assign accept = in_valid && in_ready_q;
    // The cycle right after a tb_start the traceback unit cannot yet report busy.
    assign done_fire = (state_q == StDone) && !tb_start_q && !tb_busy;

    vd_addr_gen #(
        .TB_DEPTH (TB_DEPTH),
        .AW       (AW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (done_fire),
        .adv_i      (accept),
        .addr_o     (gen_addr),
        .boundary_o (gen_boundary)
    );

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        bmc_pair_d   = bmc_pair_q;
        acs_en_d     = 1'b0;
        sm_norm_d    = 1'b0;
        norm_pend_d  = norm_pend_q;
        sv_wr_addr_d = sv_wr_addr_q;
        tb_start_d   = 1'b0;
        tb_addr_d    = tb_addr_q;
        tb_final_d   = 1'b0;
        frame_done_d = 1'b0;

        // Ignore norm_req until the normalising acs_en has been consumed.
        if (!norm_pend_q && !sm_norm_q && norm_req) begin
            norm_pend_d = 1'b1;
        end

        if (accept) begin
            bmc_pair_d   = in_pair;
            acs_en_d     = 1'b1;
            sv_wr_addr_d = gen_addr;
            sm_norm_d    = norm_pend_q;
            if (norm_pend_q) begin
                norm_pend_d = 1'b0;
            end
        end

        unique case (state_q)
            StIdle, StRun: begin
                if (accept) begin
                    state_d = StRun;
                    if (in_last) begin
                        state_d    = StFlush;
                        in_ready_d = 1'b0;
                    end else if (gen_boundary) begin
                        if (tb_busy) begin
                            state_d    = StTbWait;
                            in_ready_d = 1'b0;
                        end else begin
                            tb_start_d = 1'b1;
                            tb_addr_d  = gen_addr;
                        end
                    end
                end
            end
            StTbWait: begin
                if (!tb_busy) begin
                    tb_start_d = 1'b1;
                    tb_addr_d  = sv_wr_addr_q;
                    in_ready_d = 1'b1;
                    state_d    = StRun;
                end
            end
            StFlush: begin
                if (!tb_busy && !tb_start_q) begin
                    tb_start_d = 1'b1;
                    tb_addr_d  = sv_wr_addr_q;
                    tb_final_d = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (done_fire) begin
                    frame_done_d = 1'b1;
                    in_ready_d   = 1'b1;
                    sv_wr_addr_d = '0;
                    norm_pend_d  = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            in_ready_q   <= 1'b1;
            bmc_pair_q   <= '0;
            acs_en_q     <= 1'b0;
            sm_norm_q    <= 1'b0;
            norm_pend_q  <= 1'b0;
            sv_wr_addr_q <= '0;
            tb_start_q   <= 1'b0;
            tb_addr_q    <= '0;
            tb_final_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            bmc_pair_q   <= bmc_pair_d;
            acs_en_q     <= acs_en_d;
            sm_norm_q    <= sm_norm_d;
            norm_pend_q  <= norm_pend_d;
            sv_wr_addr_q <= sv_wr_addr_d;
            tb_start_q   <= tb_start_d;
            tb_addr_q    <= tb_addr_d;
            tb_final_q   <= tb_final_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign bmc_pair   = bmc_pair_q;
    assign acs_en     = acs_en_q;
    assign sm_norm    = sm_norm_q;
    assign sv_wr_addr = sv_wr_addr_q;
    assign tb_start   = tb_start_q;
    assign tb_addr    = tb_addr_q;
    assign tb_final   = tb_final_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vd_ctrl.sv
// Scoreboard bench for vd_ctrl: stimulus pushes expected events, a monitor
// pops and compares whenever the DUT strobes acs_en, tb_start or frame_done.
module tb_vd_ctrl;

    localparam int unsigned AW = 6;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    pair;
        logic          norm;
    } acs_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          fin;
    } tb_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    in_pair = 2'b00;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [1:0]    bmc_pair;
    logic          acs_en;
    logic          norm_req = 1'b0;
    logic          sm_norm;
    logic [AW-1:0] sv_wr_addr;
    logic          tb_start;
    logic [AW-1:0] tb_addr;
    logic          tb_final;
    logic          tb_busy = 1'b0;
    logic          frame_done;

    acs_exp_t acs_q[$];
    tb_exp_t  tbq[$];
    int       checks = 0;
    int       errors = 0;
    int       fd_expected = 0;
    int       fd_seen = 0;
    int       rdy_low_total = 0;

    vd_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_pair    (in_pair),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .bmc_pair   (bmc_pair),
        .acs_en     (acs_en),
        .norm_req   (norm_req),
        .sm_norm    (sm_norm),
        .sv_wr_addr (sv_wr_addr),
        .tb_start   (tb_start),
        .tb_addr    (tb_addr),
        .tb_final   (tb_final),
        .tb_busy    (tb_busy),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] pair_of(input int k);
        return 2'((k * 3 + 1) % 4);
    endfunction

    task automatic push_acs(input int k, input bit norm);
        acs_exp_t e;
        e.addr = AW'((k - 1) % 64);
        e.pair = pair_of(k);
        e.norm = norm;
        acs_q.push_back(e);
    endtask

    task automatic push_tb(input int addr, input bit fin);
        tb_exp_t e;
        e.addr = AW'(addr);
        e.fin  = fin;
        tbq.push_back(e);
    endtask

    // Present one symbol and return #1 after the edge that accepted it.
    task automatic drive_sym(input logic [1:0] p, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_pair  = p;
        in_last  = last;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) chk("in_ready_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input int busy_sym, input int norm_sym,
                             input bit last, input int busy_len);
        int snap;
        for (int k = 1; k <= n; k++) begin
            push_acs(k, k == norm_sym);
            if (k == norm_sym - 1) norm_req = 1'b1;
            if (k == busy_sym) tb_busy = 1'b1;
            drive_sym(pair_of(k), last && (k == n));
            norm_req = 1'b0;
            if (k == busy_sym) begin
                snap = rdy_low_total;
                repeat (busy_len - 1) @(posedge clk);
                #1;
                tb_busy = 1'b0;
                @(posedge clk);
                #1;
                chk("wait_in_ready_low_cycles", 32'(rdy_low_total - snap), 32'(busy_len));
                chk("wait_tb_start_timing", 32'(tb_start), 1);
            end
        end
    endtask

    // Emulate the traceback unit for the final launch and expect frame_done.
    task automatic finish_frame();
        int g;
        int seen0;
        g = 0;
        while (tb_start !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("final_tb_start_seen", 32'(tb_start), 1);
        tb_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        seen0 = fd_seen;
        fd_expected++;
        tb_busy = 1'b0;
        g = 0;
        while (fd_seen == seen0 && g < 10) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("frame_done_seen", 32'(fd_seen - seen0), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_bmc_pair"}, 32'(bmc_pair), 0);
        chk({tag, "_acs_en"}, 32'(acs_en), 0);
        chk({tag, "_sm_norm"}, 32'(sm_norm), 0);
        chk({tag, "_sv_wr_addr"}, 32'(sv_wr_addr), 0);
        chk({tag, "_tb_start"}, 32'(tb_start), 0);
        chk({tag, "_tb_addr"}, 32'(tb_addr), 0);
        chk({tag, "_tb_final"}, 32'(tb_final), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    // Monitor / scoreboard.
    initial begin
        acs_exp_t ea;
        tb_exp_t  et;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (in_ready == 1'b0) rdy_low_total++;
                if (acs_en) begin
                    checks++;
                    if (acs_q.size() == 0) begin
                        errors++;
                        $display("FAIL acs_unexpected: got addr %0d expected no acs_en", sv_wr_addr);
                    end else begin
                        ea = acs_q.pop_front();
                        if (sv_wr_addr !== ea.addr || bmc_pair !== ea.pair || sm_norm !== ea.norm) begin
                            errors++;
                            $display("FAIL acs_event: got addr %0d pair %0d norm %0b expected addr %0d pair %0d norm %0b",
                                     sv_wr_addr, bmc_pair, sm_norm, ea.addr, ea.pair, ea.norm);
                        end
                    end
                end
                if (tb_start) begin
                    checks++;
                    if (tbq.size() == 0) begin
                        errors++;
                        $display("FAIL tb_start_unexpected: got addr %0d final %0b expected none",
                                 tb_addr, tb_final);
                    end else begin
                        et = tbq.pop_front();
                        if (tb_addr !== et.addr || tb_final !== et.fin) begin
                            errors++;
                            $display("FAIL tb_start_event: got addr %0d final %0b expected addr %0d final %0b",
                                     tb_addr, tb_final, et.addr, et.fin);
                        end
                    end
                end
                if (frame_done) begin
                    checks++;
                    if (fd_seen >= fd_expected) begin
                        errors++;
                        $display("FAIL frame_done_unexpected: got pulse expected none (seen %0d)", fd_seen);
                    end
                    fd_seen++;
                end
            end
        end
    end

    initial begin
        #12;
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 100-symbol frame: boundary at 64 (addr 63), stalled boundary at 96
        // (addr 31), normalisation on symbol 10, final flush at addr 35.
        push_tb(63, 1'b0);
        push_tb(31, 1'b0);
        push_tb(35, 1'b1);
        run_frame(100, 96, 10, 1'b1, 5);
        finish_frame();

        // 70-symbol frame: boundary at 64, final traceback from addr 5.
        push_tb(63, 1'b0);
        push_tb(5, 1'b1);
        run_frame(70, 0, 0, 1'b1, 0);
        finish_frame();

        // Reset while stalled in the boundary wait: no further strobes.
        run_frame(63, 0, 0, 1'b0, 0);
        push_acs(64, 1'b0);
        tb_busy = 1'b1;
        drive_sym(pair_of(64), 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        tb_busy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 1);
        chk("post_reset_tb_start", 32'(tb_start), 0);

        // Single-symbol frame after the abort: address restarts at 0.
        push_acs(1, 1'b0);
        push_tb(0, 1'b1);
        drive_sym(pair_of(1), 1'b1);
        finish_frame();

        repeat (5) @(posedge clk);
        #1;
        chk("acs_queue_drained", 32'(acs_q.size()), 0);
        chk("tb_queue_drained", 32'(tbq.size()), 0);
        chk("frame_done_count", 32'(fd_seen), 32'(fd_expected));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
